// File: rtl/disp_page_mux_pkg.sv
// disp_pkg: shared constants, state type and 7-segment lookup for disp_page_mux.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic {SHOW, BLANK} disp_state_t;

  // Decimal digit to active-low 7-segment code; out-of-range values blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'd0:    seg = SEG_ZERO;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/disp_page_mux_if.sv
// disp_page_mux_if: groups the page-mux data/control inputs and display outputs.
//   tick, pages_in, btn_next, btn_prev, auto_mode : driven by the master (system side)
//   d0..d7, page_idx, page_chg                     : driven by the slave (disp_page_mux)
interface disp_page_mux_if #(
  parameter int unsigned NUM_PAGES = 4
);
  localparam int unsigned PW = $clog2(NUM_PAGES);

  logic                    tick;
  logic [NUM_PAGES*56-1:0] pages_in;
  logic                    btn_next;
  logic                    btn_prev;
  logic                    auto_mode;
  logic [6:0]              d0, d1, d2, d3, d4, d5, d6, d7;
  logic [PW-1:0]           page_idx;
  logic                    page_chg;

  modport master (
    output tick, pages_in, btn_next, btn_prev, auto_mode,
    input  d0, d1, d2, d3, d4, d5, d6, d7, page_idx, page_chg
  );

  modport slave (
    input  tick, pages_in, btn_next, btn_prev, auto_mode,
    output d0, d1, d2, d3, d4, d5, d6, d7, page_idx, page_chg
  );

endinterface

// File: rtl/disp_page_mux_edge_det.sv
// edge_det: rising-edge detector for a debounced button level.
//   clk, rst : clock, synchronous active-high reset
//   level    : debounced button level
//   pulse    : high for the cycle in which level is high and was low last cycle
// Reset loads the current level so a button held through reset is not a press.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    level_q <= level;
  end

  assign pulse = level & ~level_q & ~rst;

endmodule

// File: rtl/disp_page_mux.sv
// disp_page_mux: holds NUM_PAGES pages of eight 7-segment digit codes and presents one
// page at a time on d0..d7, with manual (next/prev) or auto-rotate page selection and a
// blanking interval after every page change.
//   clk, rst : clock, synchronous active-high reset
//   bus      : disp_page_mux_if slave (tick, pages_in, buttons, auto_mode in;
//              d0..d7, page_idx, page_chg out)
// Optional: define DISP_PAGE_IND_EN to replace digit 7 with the page number.
module disp_page_mux
  import disp_pkg::*;
#(
  parameter int unsigned NUM_PAGES   = 4,
  parameter int unsigned DWELL_TICKS = 5,
  parameter int unsigned BLANK_CYC   = 1000
) (
  input logic                 clk,
  input logic                 rst,
  disp_page_mux_if.slave      bus
);

  localparam int unsigned PW = $clog2(NUM_PAGES);
  localparam int unsigned DW = $clog2(DWELL_TICKS + 1);
  localparam int unsigned BW = $clog2(BLANK_CYC + 1);

  localparam logic [PW-1:0] LAST_PAGE  = PW'(NUM_PAGES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  disp_state_t   state_q;
  logic [PW-1:0] page_q;
  logic [DW-1:0] dwell_q;
  logic [BW-1:0] blank_q;
  logic          page_chg_q;
  logic [6:0]    d_q [8];

  logic          press_next, press_prev;
  logic          accept_next, accept_prev, auto_adv, change;
  logic [PW-1:0] page_inc, page_dec, page_new;
  logic [6:0]    page_digits [8];

  edge_det u_edge_next (
    .clk   (clk),
    .rst   (rst),
    .level (bus.btn_next),
    .pulse (press_next)
  );

  edge_det u_edge_prev (
    .clk   (clk),
    .rst   (rst),
    .level (bus.btn_prev),
    .pulse (press_prev)
  );

  always_comb begin
    // Both buttons in one cycle cancel each other.
    accept_next = press_next & ~press_prev;
    accept_prev = press_prev & ~press_next;
    auto_adv    = bus.auto_mode & bus.tick & (state_q == SHOW) & (dwell_q == DWELL_LAST);
    change      = accept_next | accept_prev | auto_adv;

    page_inc = (page_q == LAST_PAGE) ? '0 : page_q + 1'b1;
    page_dec = (page_q == '0) ? LAST_PAGE : page_q - 1'b1;
    // A press overrides a coincident auto advance; prev is the only non-increment case.
    page_new = accept_prev ? page_dec : page_inc;
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      page_digits[k] = bus.pages_in[int'(page_q)*56 + k*7 +: 7];
    end
`ifdef DISP_PAGE_IND_EN
    page_digits[7] = seg_digit(4'(page_q));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SHOW;
      page_q     <= '0;
      dwell_q    <= '0;
      blank_q    <= '0;
      page_chg_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        d_q[k] <= SEG_BLANK;
      end
    end else begin
      page_chg_q <= change;
      if (change) begin
        // Any accepted change, including one during BLANK, restarts the blank interval.
        page_q  <= page_new;
        dwell_q <= '0;
        blank_q <= '0;
        state_q <= BLANK;
      end else begin
        unique case (state_q)
          SHOW: begin
            if (!bus.auto_mode) begin
              dwell_q <= '0;
            end else if (bus.tick) begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
          BLANK: begin
            if (blank_q == BLANK_LAST) begin
              blank_q <= '0;
              state_q <= SHOW;
            end else begin
              blank_q <= blank_q + 1'b1;
            end
          end
          default: state_q <= SHOW;
        endcase
      end
      // Digits follow the current state, so the new page appears one cycle into SHOW.
      for (int k = 0; k < 8; k++) begin
        d_q[k] <= (state_q == SHOW) ? page_digits[k] : SEG_BLANK;
      end
    end
  end

  assign bus.d0       = d_q[0];
  assign bus.d1       = d_q[1];
  assign bus.d2       = d_q[2];
  assign bus.d3       = d_q[3];
  assign bus.d4       = d_q[4];
  assign bus.d5       = d_q[5];
  assign bus.d6       = d_q[6];
  assign bus.d7       = d_q[7];
  assign bus.page_idx = page_q;
  assign bus.page_chg = page_chg_q;

endmodule

// File: tb/tb_disp_page_mux.sv
// Self-checking bench for disp_page_mux: NUM_PAGES=4, DWELL_TICKS=5, BLANK_CYC=4.
// Page p digit k holds the 7-seg code of (p+k)%10.
module tb_disp_page_mux;

  localparam int unsigned NP = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  disp_page_mux_if #(.NUM_PAGES(NP)) bus ();

  disp_page_mux #(
    .NUM_PAGES   (NP),
    .DWELL_TICKS (5),
    .BLANK_CYC   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic bn;
    logic bp;
    int   idx;
    logic chg;
    int   dpage;  // -1: all digits blank
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] seg_tab [10];
  logic [6:0] dout [8];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_page;
  logic       exp_chg;

  assign dout[0] = bus.d0;
  assign dout[1] = bus.d1;
  assign dout[2] = bus.d2;
  assign dout[3] = bus.d3;
  assign dout[4] = bus.d4;
  assign dout[5] = bus.d5;
  assign dout[6] = bus.d6;
  assign dout[7] = bus.d7;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_digit(input int p, input int k);
`ifdef DISP_PAGE_IND_EN
    if (k == 7) return seg_tab[p];
`endif
    return seg_tab[(p + k) % 10];
  endfunction

  task automatic check_d(input string nm, input int dpage);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s d%0d", nm, k), 32'(dout[k]),
            (dpage < 0) ? 32'h7f : 32'(exp_digit(dpage, k)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic bn, input logic bp, input int idx, input logic chg,
                     input int dpage, input int reps = 1);
    for (int r = 0; r < reps; r++) vecs.push_back('{bn, bp, idx, chg, dpage});
  endtask

  task automatic tick_once(input string nm);
    bus.tick = 1'b1;
    step();
    check({nm, " chg"}, 32'(bus.page_chg), 32'd0);
    bus.tick = 1'b0;
    step();
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 8; k++) bus.pages_in[p*56 + k*7 +: 7] = seg_tab[(p + k) % 10];
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    bus.auto_mode = 1'b0;

    // Reset state, then page 0 one cycle after release.
    step();
    step();
    check("reset idx", 32'(bus.page_idx), 32'd0);
    check("reset chg", 32'(bus.page_chg), 32'd0);
    check_d("reset", -1);
    rst = 1'b0;
    step();
    check("post-reset idx", 32'(bus.page_idx), 32'd0);
    check("post-reset chg", 32'(bus.page_chg), 32'd0);
    check_d("post-reset", 0);

    // Manual: presses, 4 blank cycles each, wraps, simultaneous press, press during BLANK.
    add(1, 0, 1, 1, 0);
    add(1, 0, 1, 0, -1, 4);
    add(0, 0, 1, 0, 1);
    add(1, 0, 2, 1, 1);
    add(0, 0, 2, 0, -1, 4);
    add(0, 0, 2, 0, 2);
    add(1, 0, 3, 1, 2);
    add(1, 0, 3, 0, -1, 4);
    add(0, 0, 3, 0, 3);
    add(1, 0, 0, 1, 3);
    add(0, 0, 0, 0, -1, 4);
    add(0, 0, 0, 0, 0);
    add(0, 1, 3, 1, 0);
    add(0, 0, 3, 0, -1, 4);
    add(0, 0, 3, 0, 3);
    add(1, 1, 3, 0, 3);
    add(0, 0, 3, 0, 3);
    add(1, 0, 0, 1, 3);
    add(0, 0, 0, 0, -1);
    add(1, 0, 1, 1, -1);
    add(0, 0, 1, 0, -1, 4);
    add(0, 0, 1, 0, 1);
    foreach (vecs[i]) begin
      bus.btn_next = vecs[i].bn;
      bus.btn_prev = vecs[i].bp;
      step();
      check($sformatf("vec%0d idx", i), 32'(bus.page_idx), 32'(vecs[i].idx));
      check($sformatf("vec%0d chg", i), 32'(bus.page_chg), 32'(vecs[i].chg));
      check_d($sformatf("vec%0d", i), vecs[i].dpage);
    end
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;

    // Auto: tick every 10 clk, extra tick at c=192 falls in BLANK and must not count.
    bus.auto_mode = 1'b1;
    exp_page = 1;
    for (int c = 0; c <= 245; c++) begin
      bus.tick = ((c % 10) == 0) || (c == 192);
      step();
      exp_chg = (c == 40) || (c == 90) || (c == 140) || (c == 190) || (c == 240);
      if (exp_chg) exp_page = (exp_page + 1) % NP;
      check($sformatf("auto c%0d chg", c), 32'(bus.page_chg), 32'(exp_chg));
      if (exp_chg) check($sformatf("auto c%0d idx", c), 32'(bus.page_idx), 32'(exp_page));
    end
    bus.tick = 1'b0;
    check("auto end idx", 32'(bus.page_idx), 32'd2);

    // Press coinciding with the 5th dwell tick: single advance, dwell restarts.
    for (int t = 0; t < 4; t++) tick_once($sformatf("coin pre t%0d", t));
    bus.tick = 1'b1;
    bus.btn_next = 1'b1;
    step();
    check("coin chg", 32'(bus.page_chg), 32'd1);
    check("coin idx", 32'(bus.page_idx), 32'd3);
    bus.tick = 1'b0;
    bus.btn_next = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("coin blank c%0d chg", c), 32'(bus.page_chg), 32'd0);
    end
    for (int t = 0; t < 4; t++) tick_once($sformatf("coin post t%0d", t));
    check("coin dwell idx", 32'(bus.page_idx), 32'd3);
    bus.tick = 1'b1;
    step();
    check("coin 5th chg", 32'(bus.page_chg), 32'd1);
    check("coin 5th idx", 32'(bus.page_idx), 32'd0);
    bus.tick = 1'b0;
    bus.auto_mode = 1'b0;
    for (int c = 0; c < 6; c++) step();

    // Mid-run reset with btn_next held: no press after reset release.
    bus.btn_next = 1'b1;
    step();
    check("pre-rst idx", 32'(bus.page_idx), 32'd1);
    rst = 1'b1;
    step();
    check("rst idx", 32'(bus.page_idx), 32'd0);
    check("rst chg", 32'(bus.page_chg), 32'd0);
    check_d("rst", -1);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst held c%0d idx", c), 32'(bus.page_idx), 32'd0);
      check($sformatf("rst held c%0d chg", c), 32'(bus.page_chg), 32'd0);
    end
    check_d("rst held", 0);
    bus.btn_next = 1'b0;
    step();
    check("rst release chg", 32'(bus.page_chg), 32'd0);
    check("rst release idx", 32'(bus.page_idx), 32'd0);

    // Live page data reaches the digits one cycle later.
    bus.pages_in[6:0] = 7'h55;
    step();
    check("live d0", 32'(bus.d0), 32'h55);
    bus.pages_in[6:0] = seg_tab[0];
    step();
    check("live d0 restore", 32'(bus.d0), 32'(seg_tab[0]));

    // Edge detect still works after reset.
    bus.btn_next = 1'b1;
    step();
    check("post-rst press chg", 32'(bus.page_chg), 32'd1);
    check("post-rst press idx", 32'(bus.page_idx), 32'd1);
    bus.btn_next = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
